// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension and the register file write port.
// Load data arrives from the synchronous RAM during the WB cycle and is extracted combinationally.
module mem_wb_stage #(
    parameter int unsigned REG_W   = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic               flush,
    input  logic               mem_wreg,
    input  logic [RADDR_W-1:0] mem_wd,
    input  logic [REG_W-1:0]   mem_wdata,
    input  logic               mem_whilo,
    input  logic [REG_W-1:0]   mem_hi,
    input  logic [REG_W-1:0]   mem_lo,
    input  logic [2:0]         mem_ltype,
    input  logic [1:0]         mem_addr_lo,
    input  logic [REG_W-1:0]   ram_rdata,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic [REG_W-1:0]   wb_wdata,
    output logic               wb_whilo,
    output logic [REG_W-1:0]   wb_hi,
    output logic [REG_W-1:0]   wb_lo,
    output logic               wb_misalign
);

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;
    localparam logic [2:0] LT_LW  = 3'd5;

    typedef struct packed {
        logic               wreg;
        logic [RADDR_W-1:0] wd;
        logic [REG_W-1:0]   wdata;
        logic               whilo;
        logic [REG_W-1:0]   hi;
        logic [REG_W-1:0]   lo;
        logic [2:0]         ltype;
        logic [1:0]         addr_lo;
    } stage_t;

    stage_t q;
    stage_t mem_in;

    assign mem_in = '{wreg: mem_wreg, wd: mem_wd, wdata: mem_wdata, whilo: mem_whilo,
                      hi: mem_hi, lo: mem_lo, ltype: mem_ltype, addr_lo: mem_addr_lo};

    // Flush beats everything; a MEM-only stall inserts a single bubble; a full stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush || (stall[4] && !stall[5])) begin
            q <= '0;
        end else if (!stall[4]) begin
            q <= mem_in;
        end
    end

    logic [7:0]       lbyte;
    logic [15:0]      lhalf;
    logic             misalign_c;
    logic [REG_W-1:0] load_c;

    // Big-endian lane select and extension of the RAM word.
    always_comb begin
        lbyte      = '0;
        lhalf      = '0;
        misalign_c = 1'b0;
        load_c     = q.wdata;
        case (q.addr_lo)
            2'd0:    lbyte = ram_rdata[31:24];
            2'd1:    lbyte = ram_rdata[23:16];
            2'd2:    lbyte = ram_rdata[15:8];
            default: lbyte = ram_rdata[7:0];
        endcase
        lhalf = q.addr_lo[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        case (q.ltype)
            LT_LB:   load_c = {{(REG_W-8){lbyte[7]}}, lbyte};
            LT_LBU:  load_c = {{(REG_W-8){1'b0}}, lbyte};
            LT_LH: begin
                load_c     = {{(REG_W-16){lhalf[15]}}, lhalf};
                misalign_c = q.addr_lo[0];
            end
            LT_LHU: begin
                load_c     = {{(REG_W-16){1'b0}}, lhalf};
                misalign_c = q.addr_lo[0];
            end
            LT_LW: begin
                load_c     = ram_rdata;
                misalign_c = (q.addr_lo != 2'd0);
            end
            default: load_c = q.wdata;
        endcase
    end

    assign wb_we       = q.wreg && (q.wd != '0) && !misalign_c;
    assign wb_waddr    = q.wd;
    assign wb_wdata    = load_c;
    assign wb_whilo    = q.whilo;
    assign wb_hi       = q.hi;
    assign wb_lo       = q.lo;
    assign wb_misalign = misalign_c;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps plus random traffic against a behavioural stage model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic [2:0]  mem_ltype;
    logic [1:0]  mem_addr_lo;
    logic [31:0] ram_rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo;
    logic        wb_misalign;

    int errors = 0;
    int checks = 0;

    // Model of the instruction currently sitting in WB.
    logic        m_wreg;
    logic [4:0]  m_wd;
    logic [31:0] m_wdata;
    logic        m_whilo;
    logic [31:0] m_hi, m_lo;
    int          m_ltype;
    int          m_off;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_ltype(mem_ltype), .mem_addr_lo(mem_addr_lo), .ram_rdata(ram_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_wreg = 0; m_wd = 0; m_wdata = 0; m_whilo = 0;
        m_hi = 0; m_lo = 0; m_ltype = 0; m_off = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_misalign();
        if ((m_ltype == 3 || m_ltype == 4) && (m_off % 2 == 1)) return 1'b1;
        if (m_ltype == 5 && m_off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_wdata();
        int unsigned b, h;
        b = (ram_rdata >> (8 * (3 - m_off))) & 32'hFF;
        h = (ram_rdata >> (16 * (1 - m_off / 2))) & 32'hFFFF;
        case (m_ltype)
            1: return (b >= 128) ? b - 32'd256 : b;
            2: return b;
            3: return (h >= 32768) ? h - 32'd65536 : h;
            4: return h;
            5: return ram_rdata;
            default: return m_wdata;
        endcase
    endfunction

    task automatic check_all(input string tag);
        bit mis;
        mis = exp_misalign();
        chk({tag, ".we"}, 32'(wb_we), 32'(m_wreg && m_wd != 0 && !mis));
        chk({tag, ".waddr"}, 32'(wb_waddr), 32'(m_wd));
        chk({tag, ".wdata"}, wb_wdata, exp_wdata());
        chk({tag, ".whilo"}, 32'(wb_whilo), 32'(m_whilo));
        chk({tag, ".hi"}, wb_hi, m_hi);
        chk({tag, ".lo"}, wb_lo, m_lo);
        chk({tag, ".mis"}, 32'(wb_misalign), 32'(mis));
    endtask

    // One rising edge: the model applies the stage update rules to the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (flush || (stall[4] && !stall[5])) begin
            model_clear();
        end else if (!stall[4]) begin
            m_wreg = mem_wreg; m_wd = mem_wd; m_wdata = mem_wdata; m_whilo = mem_whilo;
            m_hi = mem_hi; m_lo = mem_lo; m_ltype = int'(mem_ltype); m_off = int'(mem_addr_lo);
        end
        #1;
    endtask

    task automatic set_instr(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                             input logic [2:0] lt, input logic [1:0] off);
        mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata; mem_ltype = lt; mem_addr_lo = off;
        mem_whilo = 0; mem_hi = 0; mem_lo = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; ram_rdata = 32'hDEADBEEF;
        set_instr(1, 5'd3, 32'h1111, 3'd0, 2'd0);
        model_clear();
        #12;
        check_all("reset");
        chk("reset.wdata_const", wb_wdata, 32'h0);
        @(negedge clk);
        rst = 0;

        // Plain capture
        set_instr(1, 5'd8, 32'h12345678, 3'd0, 2'd0);
        tick();
        check_all("cap");
        chk("cap.we_const", 32'(wb_we), 32'd1);
        chk("cap.waddr_const", 32'(wb_waddr), 32'd8);
        chk("cap.wdata_const", wb_wdata, 32'h12345678);

        // Load extraction from 0x80FF7F01
        ram_rdata = 32'h80FF7F01;
        set_instr(1, 5'd9, 32'h0, 3'd1, 2'd0); tick();
        check_all("lb0"); chk("lb0.const", wb_wdata, 32'hFFFFFF80);
        set_instr(1, 5'd9, 32'h0, 3'd2, 2'd1); tick();
        check_all("lbu1"); chk("lbu1.const", wb_wdata, 32'h000000FF);
        set_instr(1, 5'd9, 32'h0, 3'd3, 2'd2); tick();
        check_all("lh2"); chk("lh2.const", wb_wdata, 32'h00007F01);
        set_instr(1, 5'd9, 32'h0, 3'd4, 2'd0); tick();
        check_all("lhu0"); chk("lhu0.const", wb_wdata, 32'h000080FF);
        set_instr(1, 5'd9, 32'h0, 3'd5, 2'd0); tick();
        check_all("lw"); chk("lw.const", wb_wdata, 32'h80FF7F01);

        // Misalignment and recovery
        set_instr(1, 5'd9, 32'h0, 3'd5, 2'd2); tick();
        check_all("lw_mis");
        chk("lw_mis.flag", 32'(wb_misalign), 32'd1);
        chk("lw_mis.we", 32'(wb_we), 32'd0);
        set_instr(1, 5'd9, 32'h0, 3'd3, 2'd1); tick();
        check_all("lh_mis");
        chk("lh_mis.flag", 32'(wb_misalign), 32'd1);
        set_instr(1, 5'd9, 32'h0, 3'd3, 2'd0); tick();
        check_all("lh_ok");
        chk("lh_ok.flag", 32'(wb_misalign), 32'd0);
        chk("lh_ok.we", 32'(wb_we), 32'd1);

        // Register 0 and HI/LO
        set_instr(1, 5'd0, 32'hCAFE, 3'd0, 2'd0); tick();
        check_all("r0"); chk("r0.we", 32'(wb_we), 32'd0);
        set_instr(0, 5'd0, 32'h0, 3'd0, 2'd0);
        mem_whilo = 1; mem_hi = 32'hA; mem_lo = 32'hB; tick();
        check_all("hilo");
        chk("hilo.whilo", 32'(wb_whilo), 32'd1);
        chk("hilo.hi", wb_hi, 32'hA);
        chk("hilo.lo", wb_lo, 32'hB);

        // Stall and flush
        set_instr(1, 5'd8, 32'h55AA55AA, 3'd0, 2'd0); tick();
        stall = 6'b010000; tick();
        check_all("bubble"); chk("bubble.we", 32'(wb_we), 32'd0);
        stall = 6'b000000; tick();
        set_instr(1, 5'd17, 32'h0BADF00D, 3'd0, 2'd0);
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("hold");
            chk("hold.waddr", 32'(wb_waddr), 32'd8);
            chk("hold.wdata", wb_wdata, 32'h55AA55AA);
        end
        flush = 1; tick();
        check_all("flush"); chk("flush.we", 32'(wb_we), 32'd0);
        flush = 0; stall = 0; tick();
        check_all("after_flush"); chk("after_flush.waddr", 32'(wb_waddr), 32'd17);

        // Asynchronous reset while a valid write is held
        stall = 6'b110000; tick();
        #3; rst = 1; #1;
        model_clear();
        check_all("async_rst");
        chk("async_rst.we", 32'(wb_we), 32'd0);
        @(negedge clk); rst = 0;
        set_instr(1, 5'd21, 32'h77, 3'd0, 2'd0);
        tick();
        check_all("post_rst_stalled"); chk("post_rst_stalled.we", 32'(wb_we), 32'd0);
        stall = 0; tick();
        check_all("post_rst_cap"); chk("post_rst_cap.waddr", 32'(wb_waddr), 32'd21);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            mem_wreg    = 1'($urandom_range(0, 1));
            mem_wd      = 5'($urandom);
            mem_wdata   = $urandom;
            mem_whilo   = 1'($urandom_range(0, 1));
            mem_hi      = $urandom;
            mem_lo      = $urandom;
            mem_ltype   = 3'($urandom_range(0, 7));
            mem_addr_lo = 2'($urandom);
            stall       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            flush       = ($urandom_range(0, 15) == 0);
            tick();
            ram_rdata   = $urandom;
            #1;
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and write-back datapath between the MEM stage and the general-purpose register file. Captures each retiring instruction's destination, ALU result, HI/LO update and load descriptor, and honours pipeline stall/flush. Aligns and sign/zero-extends load data returned one cycle late by the synchronous data RAM. Drives the register file's single write port (`we`, `waddr`, `wdata`) and the HI/LO write port.

## Interface
- `REG_W`, 32: data width of GPRs, HI, LO and RAM read data.
- `RADDR_W`, 5: register address width (32 registers).
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `stall`  in  6  pipeline stall vector; bit 4 means the MEM stage is stalled, bit 5 means the WB stage is stalled.
- `flush`  in  1  exception flush; kills the instruction entering WB.
- `mem_wreg`  in  1  MEM instruction writes a GPR.
- `mem_wd`  in  RADDR_W  destination GPR address.
- `mem_wdata`  in  REG_W  non-load result.
- `mem_whilo`  in  1  MEM instruction writes HI/LO.
- `mem_hi`, `mem_lo`  in  REG_W  HI/LO values.
- `mem_ltype`  in  3  load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6 and 7 are treated as none.
- `mem_addr_lo`  in  2  byte offset of the load address.
- `ram_rdata`  in  REG_W  data RAM read word, valid in the cycle the load occupies WB.
- `wb_we`  out  1  register file write enable.
- `wb_waddr`  out  RADDR_W  register file write address.
- `wb_wdata`  out  REG_W  register file write data.
- `wb_whilo`  out  1  HI/LO write enable.
- `wb_hi`, `wb_lo`  out  REG_W  HI/LO write data.
- `wb_misalign`  out  1  held load is misaligned; the write is suppressed.

## Operation
- Stage registers hold: `wreg`, `wd`, `wdata`, `whilo`, `hi`, `lo`, `ltype`, `addr_lo`.
- Per rising edge, in priority order:
  - `flush`=1: load a bubble (all registers 0).
  - `stall[4]`=1 and `stall[5]`=0: load a bubble.
  - `stall[4]`=0: capture all MEM inputs.
  - Otherwise (both stalled): hold.
- Load extraction is big-endian. Offset 0 selects bits 31:24; offset 3 selects bits 7:0. Halfword offset 0 selects bits 31:16; offset 2 selects bits 15:0.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Misalignment:
  - LH/LHU with an odd offset, or LW with a nonzero offset, is misaligned.
  - A misaligned load sets `wb_misalign`=1 and forces `wb_we`=0.
- `wb_wdata` is the extracted value when `ltype` is 1..5, otherwise the registered `wdata`.
- `wb_we` = `wreg` and (`wd` != 0) and not misaligned. Register 0 is never written.
- `wb_waddr` = `wd`.
- `wb_whilo`, `wb_hi`, `wb_lo` are driven directly from their registers.
- A byte or halfword load with an unused offset takes its lane from the offset bits only. No other exception is raised.

## Timing
- Latency: an instruction captured at edge N presents its outputs from N+clk-to-q until edge N+1 or later, depending on stall.
- `wb_wdata` for loads is combinational from `ram_rdata` within that same cycle. The RAM read address must therefore have been registered at edge N.
- Reset: every stage register clears immediately on `rst`, without waiting for a clock edge. While in reset: `wb_we`=0, `wb_waddr`=0, `wb_wdata`=`ram_rdata`-independent 0, `wb_whilo`=0, `wb_hi`=0, `wb_lo`=0, `wb_misalign`=0.
- Reset asserted mid-stall discards the held instruction. The first capture after reset release occurs at the first edge with `stall[4]`=0.
- `flush` coincident with any stall pattern yields a bubble; flush wins.
- During a WB stall the held outputs stay stable, so the register file may see repeated identical writes. Repeated writes are benign.
- A bubble is issued once, and only when MEM stalls while WB proceeds. No instruction is duplicated or lost across the stall boundaries.

## Test plan
- Capture: `mem_wreg`=1, `mem_wd`=8, `mem_wdata`=0x12345678, `mem_ltype`=0, no stall. After one edge: `wb_we`=1, `wb_waddr`=8, `wb_wdata`=0x12345678.
- Loads with `ram_rdata`=0x80FF7F01:
  - LB offset 0 -> 0xFFFFFF80.
  - LBU offset 1 -> 0x000000FF.
  - LH offset 2 -> 0x00007F01.
  - LHU offset 0 -> 0x000080FF.
  - LW -> 0x80FF7F01.
- Misalignment: LW with offset 2, or LH with offset 1 -> `wb_misalign`=1 and `wb_we`=0. A following aligned load clears both.
- Register 0 and HI/LO: `mem_wd`=0 with `mem_wreg`=1 -> `wb_we`=0. `mem_whilo`=1, hi=0xA, lo=0xB -> `wb_whilo`=1, `wb_hi`=0xA, `wb_lo`=0xB.
- Stall and flush:
  - `stall`=6'b010000 -> bubble (`wb_we`=0).
  - `stall`=6'b110000 -> outputs held across 3 edges.
  - `flush`=1 together with `stall`=6'b110000 -> bubble.
- Asynchronous reset: assert `rst` mid-cycle while a valid write is held. All outputs go to 0 before the next edge. After release, the first capture occurs with `stall[4]`=0.
